// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU engine for the HI/LO path: XLEN shift-add or
// restoring-divide steps, a sign-fix cycle, then a one-cycle HI/LO write pulse.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            hilo_read,
    input  logic            kill,
    output logic            busy,
    output logic            stall,
    output logic            result_valid,
    output logic [XLEN-1:0] hi_out,
    output logic [XLEN-1:0] lo_out
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t state, state_next;

    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  acc_hi, acc_lo, operand, a_raw;
    logic             is_div, div_zero, neg_lo, neg_hi;

    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;

    logic [XLEN:0]   mul_sum, mul_pre, div_shift, div_trial;
    logic [XLEN-1:0] step_hi, step_lo;

    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   fix_hi, fix_lo;

    // Magnitudes only for the signed ops; unsigned ops pass raw values.
    always_comb begin
        a_neg = ~op[0] & op_a[XLEN-1];
        b_neg = ~op[0] & op_b[XLEN-1];
        a_mag = a_neg ? -op_a : op_a;
        b_mag = b_neg ? -op_b : op_b;
    end

    // One iteration. Multiply: acc_hi is the upper product half, acc_lo holds
    // the multiplier shifting out. Divide: acc_hi is rem, acc_lo is quot.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + {1'b0, operand};
        mul_pre   = acc_lo[0] ? mul_sum : {1'b0, acc_hi};
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_trial = div_shift - {1'b0, operand};
        step_hi   = '0;
        step_lo   = '0;
        if (!is_div) begin
            step_hi = mul_pre[XLEN:1];
            step_lo = {mul_pre[0], acc_lo[XLEN-1:1]};
        end else if (!div_trial[XLEN]) begin
            step_hi = div_trial[XLEN-1:0];
            step_lo = {acc_lo[XLEN-2:0], 1'b1};
        end else begin
            step_hi = div_shift[XLEN-1:0];
            step_lo = {acc_lo[XLEN-2:0], 1'b0};
        end
    end

    // Overflow (MIN / -1) falls out of the magnitude path; only /0 is forced.
    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_fix = neg_lo ? -prod : prod;
        fix_hi   = prod_fix[2*XLEN-1:XLEN];
        fix_lo   = prod_fix[XLEN-1:0];
        if (is_div) begin
            if (div_zero) begin
                fix_hi = a_raw;
                fix_lo = '1;
            end else begin
                fix_hi = neg_hi ? -acc_hi : acc_hi;
                fix_lo = neg_lo ? -acc_lo : acc_lo;
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (cnt == LAST) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (kill) state_next = IDLE;

        busy         = (state != IDLE);
        stall        = busy && (start || hilo_read);
        result_valid = (state == DONE) && !kill && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            operand  <= '0;
            a_raw    <= '0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
        end else begin
            unique case (state)
                IDLE: if (start && !kill) begin
                    cnt      <= '0;
                    is_div   <= op[1];
                    operand  <= op[1] ? b_mag : a_mag;
                    acc_hi   <= '0;
                    acc_lo   <= op[1] ? a_mag : b_mag;
                    a_raw    <= op_a;
                    div_zero <= (op_b == '0);
                    neg_lo   <= a_neg ^ b_neg;
                    neg_hi   <= a_neg;
                end
                CALC: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt + CNT_W'(1);
                end
                FIX: if (!kill) begin
                    hi_out <= fix_hi;
                    lo_out <= fix_lo;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed ops push expected HI/LO and
// completion cycle; a negedge monitor pops and compares on result_valid.
`timescale 1ns/1ps
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, hilo_read, kill;
    logic [1:0]  op;
    logic [31:0] op_a, op_b;
    logic        busy, stall, result_valid;
    logic [31:0] hi_out, lo_out;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
        .hilo_read(hilo_read), .kill(kill), .busy(busy), .stall(stall),
        .result_valid(result_valid), .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          at;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
    } vec_t;
    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (result_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid hi=%h lo=%h (cycle %0d)", hi_out, lo_out, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("hi", hi_out, mon_e.hi);
                chk("lo", lo_out, mon_e.lo);
                chk("latency", cyc, mon_e.at);
            end
        end
    end

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input logic [31:0] eh, input logic [31:0] el, input int at);
        exp_t e;
        e.hi = eh;
        e.lo = el;
        e.at = at;
        exp_q.push_back(e);
    endtask

    // Presents one op for a single cycle while idle; returns in the next cycle.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input bit push);
        op = o; op_a = a; op_b = b; start = 1'b1;
        if (push) push_exp(eh, el, cyc + 34);
        #1;
        chk("stall_when_idle", stall, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 80) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) chk("idle_timeout", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int n;
        vecs[0] = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1] = '{2'b00, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2] = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[4] = '{2'b11, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF};
        vecs[5] = '{2'b10, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
        vecs[6] = '{2'b11, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
        vecs[7] = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[8] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[9] = '{2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};

        rst = 1'b1; start = 1'b0; kill = 1'b0; hilo_read = 1'b0;
        op = 2'b00; op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_stall", stall, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_hi", hi_out, 0);
        chk("rst_lo", lo_out, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // MULTU max x max with busy window edges
        n = cyc;
        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b1);
        goto(n + 34);
        chk("busy_last", busy, 1);
        goto(n + 35);
        chk("busy_released", busy, 0);

        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 1'b1);
            wait_idle();
        end

        // MFHI/MFLO stall plus back-to-back start held by stall
        n = cyc;
        issue(2'b01, 32'h00000002, 32'h00000003, 32'h00000000, 32'h00000006, 1'b1);
        goto(n + 4);
        chk("stall_before_read", stall, 0);
        goto(n + 5);
        hilo_read = 1'b1;
        #1;
        chk("stall_read", stall, 1);
        goto(n + 10);
        op = 2'b11; op_a = 32'h00000064; op_b = 32'h00000007; start = 1'b1;
        for (int c = n + 10; c <= n + 34; c++) begin
            goto(c);
            #1;
            chk("stall_hold", stall, 1);
        end
        goto(n + 35);
        chk("stall_release", stall, 0);
        chk("busy_release", busy, 0);
        push_exp(32'h00000002, 32'h0000000E, n + 69);
        goto(n + 36);
        start = 1'b0;
        hilo_read = 1'b0;
        chk("busy_second", busy, 1);
        wait_idle();

        // kill mid-calculation
        n = cyc;
        issue(2'b01, 32'h00000005, 32'h00000005, 32'h0, 32'h0, 1'b0);
        goto(n + 10);
        kill = 1'b1;
        goto(n + 11);
        kill = 1'b0;
        chk("kill_busy", busy, 0);
        chk("kill_hi", hi_out, 32'h00000002);
        chk("kill_lo", lo_out, 32'h0000000E);
        goto(n + 45);
        chk("kill_hi_late", hi_out, 32'h00000002);

        // kill together with start in IDLE
        op = 2'b01; op_a = 32'h3; op_b = 32'h3; start = 1'b1; kill = 1'b1;
        goto(cyc + 1);
        start = 1'b0; kill = 1'b0;
        chk("kill_start_busy", busy, 0);
        goto(cyc + 40);
        chk("kill_start_lo", lo_out, 32'h0000000E);

        // reset during a DIV, then a fresh op
        n = cyc;
        issue(2'b10, 32'hFFFFFF9C, 32'h00000007, 32'h0, 32'h0, 1'b0);
        goto(n + 20);
        rst = 1'b1;
        goto(n + 21);
        rst = 1'b0;
        chk("mrst_busy", busy, 0);
        chk("mrst_stall", stall, 0);
        chk("mrst_valid", result_valid, 0);
        chk("mrst_hi", hi_out, 0);
        chk("mrst_lo", lo_out, 0);
        goto(n + 22);
        issue(2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b1);
        wait_idle();

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multiply/divide sequencer for the HI/LO path of the pipelined core. It accepts MULT, MULTU, DIV and DIVU from the EX stage and runs a 32-step shift-add or restoring-divide engine. It produces a one-cycle HI/LO write pulse on completion. While the engine is busy, it stalls the front end whenever a new mul/div or an MFHI/MFLO would observe stale HI/LO.

## Interface
- XLEN, 32, operand width; the iteration count equals XLEN

- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  EX stage holds a mul/div instruction; the operands are valid this cycle
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- op_a  in  XLEN  rs value, after forwarding
- op_b  in  XLEN  rt value, after forwarding
- hilo_read  in  1  ID stage holds MFHI or MFLO
- kill  in  1  squash the operation in flight (exception/flush)
- busy  out  1  engine occupied
- stall  out  1  freeze PC, IF/ID and ID/EX
- result_valid  out  1  one-cycle write pulse for the HI/LO registers
- hi_out  out  XLEN  high product, or remainder
- lo_out  out  XLEN  low product, or quotient

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - When start=1 and kill=0, latch op, |op_a| and |op_b| (raw values for the unsigned ops), and the result signs. Clear the accumulator and set cnt=0. Go to CALC.
- CALC: one step per cycle, then cnt+1. After the step with cnt=XLEN-1, go to FIX.
  - Multiply step: if multiplier bit0=1, add the multiplicand into the upper half of a 2·XLEN accumulator (XLEN+1-bit add so the carry is kept). Then shift the accumulator and multiplier right by 1.
  - Divide step: restoring division. Shift {rem, quot} left by 1, then trial-subtract the divisor from rem over XLEN+1 bits. If the result is non-negative, keep it and set quot bit0=1; otherwise restore rem and set bit0=0.
- FIX: apply the sign corrections, register them into hi_out/lo_out, and go to DONE.
  - MULT: negate the 64-bit product when the operand signs differ.
  - DIV: the quotient is negated when the signs differ. The remainder takes the sign of the dividend.
  - 0x80000000 / -1 (DIV): lo=0x80000000, hi=0.
  - Divide by zero (DIV or DIVU): hi=op_a as presented, lo=0xFFFFFFFF. The full latency still applies.
- DONE: result_valid=1 for this cycle only, then go to IDLE.
- busy = (state != IDLE).
- stall = busy && (start || hilo_read). Combinational.
  - A start arriving while busy is not accepted.
  - The pipeline re-presents that instruction, and it is accepted in the first IDLE cycle.
- kill:
  - Any state returns to IDLE at the next edge. No result_valid is produced and hi_out/lo_out are unchanged.
  - In IDLE, kill blocks a simultaneous start.
  - In DONE, kill forces result_valid=0 in that cycle.
- Reset values: state=IDLE, cnt=0, busy=0, stall=0, result_valid=0, hi_out=0, lo_out=0, accumulators=0.
- Reset mid-operation aborts exactly like kill, and also clears hi_out/lo_out.

## Timing
- Start is sampled high in cycle N (the edge at the end of N).
- Cycles N+1 through N+32 are CALC. Cycle N+33 is FIX.
- Cycle N+34 is DONE: result_valid=1 and hi_out/lo_out hold the final values.
- The HI/LO registers update at the end of N+34.
- busy=1 from N+1 through N+34 inclusive.
- An MFHI/MFLO stalled in ID is released in N+35 and reads the updated HI/LO.
- A back-to-back mul/div held by stall is accepted in N+35; its result_valid comes in N+69.
- hi_out/lo_out hold their values after DONE until the next FIX.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, start at N -> busy from N+1; result_valid only in N+34 with hi=0xFFFFFFFE, lo=0x00000001.
- MULT -3 × 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 0x1234 / 0 -> hi=0x00001234, lo=0xFFFFFFFF in N+34.
- MULTU started at N, hilo_read=1 from N+5 -> stall=1 in N+5 through N+34 and 0 in N+35. In the same run, a second start held from N+10 is accepted at N+35; its result_valid comes in N+69.
- kill at N+10 -> IDLE at N+11, no result_valid, hi/lo unchanged. kill together with start in IDLE -> no operation begins.
- rst=1 at N+20 of a DIV -> next cycle all outputs 0, state IDLE. A new start one cycle later completes normally 34 cycles after it is sampled.
